// File: rtl/risc_pkg.sv
// risc_pkg: shared constants for the 16-bit pipelined RISC datapath.
//   - ALU opcode encodings (as carried on in_alu_op)
//   - conditional-branch condition encodings (as carried on in_br_cond)
//   - bit positions inside the 5-bit architectural status register
package risc_pkg;

  // ALU opcodes
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;

  // Branch conditions
  localparam logic [2:0] BR_NEVER  = 3'd0;
  localparam logic [2:0] BR_EQ     = 3'd1;
  localparam logic [2:0] BR_NE     = 3'd2;
  localparam logic [2:0] BR_LT     = 3'd3;
  localparam logic [2:0] BR_GT     = 3'd4;
  localparam logic [2:0] BR_LE     = 3'd5;
  localparam logic [2:0] BR_GE     = 3'd6;
  localparam logic [2:0] BR_ALWAYS = 3'd7;

  // Status register layout: {lt, eq, gt, carry, ovf}
  localparam int STAT_LT    = 4;
  localparam int STAT_EQ    = 3;
  localparam int STAT_GT    = 2;
  localparam int STAT_CARRY = 1;
  localparam int STAT_OVF   = 0;
  localparam int STAT_W     = 5;

endpackage

// File: rtl/br_eval.sv
// br_eval: combinational branch-decision mapping.
// Ports:
//   br_cond in 3 : condition code (never/eq/ne/lt/gt/le/ge/always)
//   lt, eq, gt in 1 : compare flags of the result being evaluated
//   taken out 1  : branch outcome
import risc_pkg::*;

module br_eval (
  input  logic [2:0] br_cond,
  input  logic       lt,
  input  logic       eq,
  input  logic       gt,
  output logic       taken
);

  // Decode the condition code against the compare flags
  always_comb begin
    taken = 1'b0;
    case (br_cond)
      BR_NEVER:  taken = 1'b0;
      BR_EQ:     taken = eq;
      BR_NE:     taken = ~eq;
      BR_LT:     taken = lt;
      BR_GT:     taken = gt;
      BR_LE:     taken = lt | eq;
      BR_GE:     taken = gt | eq;
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-stage back end. Accepts one ALU result per cycle
// over valid/ready, buffers up to two results in a skid FIFO, updates the
// architectural status flags and resolves the branch decision at push time.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : upstream handshake (in_ready from count only)
//   in_data, in_rd             : result and destination register
//   in_lt/eq/gt/carry/ovf      : ALU flags
//   in_alu_op                  : opcode that produced the result
//   in_set_flags               : result updates status
//   in_br_cond                 : branch condition code
//   out_valid/out_ready        : downstream handshake
//   out_data/out_rd/out_br_taken : FIFO head entry
//   status                     : {lt, eq, gt, carry, ovf}
//   trap, trap_clr             : sticky overflow trap and its clear
// Build option: define ALU_RESULT_STAGE_OVF_TRAP_EN to enable the overflow
// trap; without it trap is tied low and trap_clr is ignored.
import risc_pkg::*;

module alu_result_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_lt,
  input  logic              in_eq,
  input  logic              in_gt,
  input  logic              in_carry,
  input  logic              in_ovf,
  input  logic [2:0]        in_alu_op,
  input  logic              in_set_flags,
  input  logic [2:0]        in_br_cond,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_br_taken,
  output logic [4:0]        status,
  output logic              trap,
  input  logic              trap_clr
);

  logic [1:0][DATA_W-1:0] data_q, data_d;
  logic [1:0][RD_W-1:0]   rd_q, rd_d;
  logic [1:0]             taken_q, taken_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic [4:0]             status_q, status_d;
  logic                   push_s;
  logic                   pop_s;
  logic                   br_taken_s;

  br_eval u_br_eval (
    .br_cond (in_br_cond),
    .lt      (in_lt),
    .eq      (in_eq),
    .gt      (in_gt),
    .taken   (br_taken_s)
  );

  // Ready depends only on registered occupancy, never on out_ready
  assign in_ready     = (count_q != 2'd2);
  assign out_valid    = (count_q != 2'd0);
  assign push_s       = in_valid & in_ready;
  assign pop_s        = out_valid & out_ready;
  assign out_data     = data_q[rd_ptr_q];
  assign out_rd       = rd_q[rd_ptr_q];
  assign out_br_taken = taken_q[rd_ptr_q];
  assign status       = status_q;

  // Next-state for FIFO storage, pointers, occupancy and status flags
  always_comb begin
    data_d   = data_q;
    rd_d     = rd_q;
    taken_d  = taken_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    status_d = status_q;

    if (push_s) begin
      data_d[wr_ptr_q]  = in_data;
      rd_d[wr_ptr_q]    = in_rd;
      taken_d[wr_ptr_q] = br_taken_s;
      wr_ptr_d          = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (push_s && in_set_flags) begin
      status_d = 5'd0;
      status_d[STAT_LT]    = in_lt;
      status_d[STAT_EQ]    = in_eq;
      status_d[STAT_GT]    = in_gt;
      status_d[STAT_CARRY] = in_carry;
      status_d[STAT_OVF]   = in_ovf;
    end else begin
      status_d = status_q;
    end
  end

  // FIFO, pointer, occupancy and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      rd_q     <= '0;
      taken_q  <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      status_q <= 5'd0;
    end else begin
      data_q   <= data_d;
      rd_q     <= rd_d;
      taken_q  <= taken_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

`ifdef ALU_RESULT_STAGE_OVF_TRAP_EN
  logic trap_q, trap_d;
  logic trap_set_s;

  // Only arithmetic ops can raise the overflow trap
  assign trap_set_s = push_s & in_ovf & ((in_alu_op == ALU_ADD) | (in_alu_op == ALU_SUB));
  assign trap       = trap_q;

  // Sticky trap: set has priority over clear
  always_comb begin
    trap_d = trap_q;
    if (trap_set_s) begin
      trap_d = 1'b1;
    end else if (trap_clr) begin
      trap_d = 1'b0;
    end else begin
      trap_d = trap_q;
    end
  end

  // Trap flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
`else
  logic [3:0] unused_trap_inputs_s;

  assign trap                 = 1'b0;
  assign unused_trap_inputs_s = {trap_clr, in_alu_op};
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_lt, in_eq, in_gt, in_carry, in_ovf;
  logic [2:0]  in_alu_op;
  logic        in_set_flags;
  logic [2:0]  in_br_cond;
  logic [2:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_rd;
  logic        out_br_taken;
  logic [4:0]  status;
  logic        trap;
  logic        trap_clr;

  int tests = 0;
  int fails = 0;

  alu_result_stage #(.DATA_W(16), .RD_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_lt(in_lt), .in_eq(in_eq), .in_gt(in_gt), .in_carry(in_carry), .in_ovf(in_ovf),
    .in_alu_op(in_alu_op), .in_set_flags(in_set_flags), .in_br_cond(in_br_cond),
    .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_br_taken(out_br_taken),
    .status(status), .trap(trap), .trap_clr(trap_clr)
  );

  always #5 clk = ~clk;

  // Reference model
  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        taken;
  } entry_t;

  entry_t     q[$];
  logic [4:0] m_status;
  logic       m_trap;

`ifdef ALU_RESULT_STAGE_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  function automatic logic ref_taken(input int cond, input logic lt, input logic eq, input logic gt);
    bit less = lt, same = eq, more = gt;
    case (cond)
      0: return 1'b0;
      1: return same;
      2: return !same;
      3: return less;
      4: return more;
      5: return less || same;
      6: return more || same;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic lt, input logic eq,
                       input logic gt, input logic c, input logic o, input logic [2:0] op,
                       input logic sf, input logic [2:0] cond, input logic [2:0] rd);
    in_valid = v; in_data = d; in_lt = lt; in_eq = eq; in_gt = gt; in_carry = c;
    in_ovf = o; in_alu_op = op; in_set_flags = sf; in_br_cond = cond; in_rd = rd;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, in_ready, q.size() != 2);
    chk({tag, ".out_valid"}, out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk({tag, ".out_data"}, out_data, q[0].data);
      chk({tag, ".out_rd"}, out_rd, q[0].rd);
      chk({tag, ".out_br_taken"}, out_br_taken, q[0].taken);
    end
    chk({tag, ".status"}, status, m_status);
    chk({tag, ".trap"}, trap, m_trap);
  endtask

  // One clock: predict from current inputs, clock, then compare
  task automatic step(input string tag);
    bit push, pop, tset;
    entry_t e;
    push = in_valid && (q.size() < 2);
    pop  = out_ready && (q.size() > 0);
    e.data = in_data; e.rd = in_rd; e.taken = ref_taken(in_br_cond, in_lt, in_eq, in_gt);
    tset = push && in_ovf && (in_alu_op == 3'd2 || in_alu_op == 3'd6);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    if (push && in_set_flags) m_status = {in_lt, in_eq, in_gt, in_carry, in_ovf};
    if (TRAP_EN) begin
      if (tset) m_trap = 1'b1;
      else if (trap_clr) m_trap = 1'b0;
    end
    check_all(tag);
  endtask

  typedef struct {
    logic [2:0] cond;
    logic       lt, eq, gt;
    logic       exp;
  } br_vec_t;

  br_vec_t vecs[12];

  initial begin
    vecs[0]  = '{3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3'd4, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{3'd5, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{3'd5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'd6, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{3'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'd7, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; out_ready = 1'b1; trap_clr = 1'b0;
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
    q.delete(); m_status = 5'd0; m_trap = 1'b0;
    #12;
    // Reset values
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.out_data", out_data, 16'd0);
    chk("rst.out_rd", out_rd, 3'd0);
    chk("rst.out_br_taken", out_br_taken, 1'b0);
    chk("rst.status", status, 5'd0);
    chk("rst.trap", trap, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push, lt branch taken
    drive(1'b1, 16'd500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd3, 3'd1);
    step("p1");
    chk("p1.data500", out_data, 16'd500);
    chk("p1.taken", out_br_taken, 1'b1);
    chk("p1.status", status, 5'b10000);

    // Back-to-back eq/gt with ne condition
    drive(1'b1, 16'd1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 3'd2, 3'd2);
    step("b2b1");
    chk("b2b1.data", out_data, 16'd1000);
    chk("b2b1.taken", out_br_taken, 1'b0);
    drive(1'b1, 16'd1500, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 3'd2, 3'd3);
    step("b2b2");
    chk("b2b2.data", out_data, 16'd1500);
    chk("b2b2.taken", out_br_taken, 1'b1);
    chk("b2b2.in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    step("b2b.drain");

    // Fill with out_ready low: third offer held
    out_ready = 1'b0;
    drive(1'b1, 16'd11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd1, 3'd4);
    step("full1");
    drive(1'b1, 16'd22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 3'd3, 3'd5);
    step("full2");
    chk("full2.in_ready0", in_ready, 1'b0);
    drive(1'b1, 16'd33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 3'd4, 3'd6);
    step("full3");
    chk("full3.held", out_data, 16'd11);
    chk("full.status_sf0", status, 5'b01010);
    out_ready = 1'b1;
    step("drain1");
    chk("drain1.in_ready1", in_ready, 1'b1);
    chk("drain1.head22", out_data, 16'd22);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("drain");

    // Overflow trap: set, persist, clear
    drive(1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 3'd0, 3'd7);
    step("trap.set");
    chk("trap.set", trap, TRAP_EN);
    drive(1'b1, 16'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 3'd1);
    step("trap.hold");
    chk("trap.persist", trap, TRAP_EN);
    in_valid = 1'b0; trap_clr = 1'b1;
    step("trap.clr");
    chk("trap.cleared", trap, 1'b0);
    trap_clr = 1'b0;
    drive(1'b1, 16'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 3'd1);
    step("trap.and_ovf");
    chk("trap.no_set_on_and", trap, 1'b0);
    in_valid = 1'b0;
    step("trap.idle");

    // Branch-condition table
    foreach (vecs[i]) begin
      drive(1'b1, 16'(i * 37 + 100), vecs[i].lt, vecs[i].eq, vecs[i].gt, 1'b0, 1'b0,
            3'd1, 1'b1, vecs[i].cond, 3'(i));
      step("brtab");
      chk($sformatf("brtab[%0d].taken", i), out_br_taken, vecs[i].exp);
    end
    in_valid = 1'b0;
    step("brtab.drain");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [2:0] op;
      case ($urandom_range(0, 3))
        0: op = 3'd0;
        1: op = 3'd1;
        2: op = 3'd2;
        default: op = 3'd6;
      endcase
      drive($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0, op, 1'($urandom), 3'($urandom), 3'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      trap_clr  = $urandom_range(0, 7) == 0;
      step("rand");
    end
    trap_clr = 1'b0;

    // Fill two entries, then async reset mid-cycle
    out_ready = 1'b0;
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 3'd7, 3'd3);
    step("pre_rst");
    step("pre_rst");
    chk("pre_rst.full", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", out_valid, 1'b0);
    chk("arst.status", status, 5'd0);
    chk("arst.in_ready", in_ready, 1'b1);
    chk("arst.out_data", out_data, 16'd0);
    chk("arst.trap", trap, 1'b0);
    q.delete(); m_status = 5'd0; m_trap = 1'b0;
    @(posedge clk); #1;
    chk("arst.no_push", out_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'd77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 3'd1, 3'd2);
    step("post_rst");
    chk("post_rst.data", out_data, 16'd77);
    in_valid = 1'b0;
    step("post_rst.idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-stage back end of the 16-bit pipelined RISC datapath. Accepts one ALU result per cycle together with its compare and arithmetic flags over a valid/ready handshake. Buffers up to two results in a skid FIFO and updates the architectural status-flag register. Resolves the conditional-branch decision and presents result, destination register and branch outcome to the memory/writeback stage.

## Interface
- `DATA_W`, 16: ALU result width.
- `RD_W`, 3: destination register index width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream result valid.
- `in_ready` out 1: stage can accept a result.
- `in_data` in DATA_W: ALU `out`.
- `in_lt`, `in_eq`, `in_gt`, `in_carry`, `in_ovf` in 1 each: ALU flags.
- `in_alu_op` in 3: opcode that produced the result (0 AND, 1 OR, 2 ADD, 6 SUB).
- `in_set_flags` in 1: result updates the status register.
- `in_br_cond` in 3: 0 never, 1 eq, 2 ne, 3 lt, 4 gt, 5 le, 6 ge, 7 always.
- `in_rd` in RD_W: destination register.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out DATA_W, `out_rd` out RD_W, `out_br_taken` out 1: head entry fields.
- `status` out 5: {lt, eq, gt, carry, ovf} architectural flags.
- `trap` out 1: overflow trap, sticky (see Configuration).
- `trap_clr` in 1: clears `trap`.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Storage is a 2-entry FIFO of {data, rd, br_taken}, with a read pointer, a write pointer and a 2-bit count.
- `br_taken` is evaluated combinationally at push from the incoming flags (`in_lt`/`in_eq`/`in_gt`), not from `status`:
  - le = lt|eq, ge = gt|eq, ne = !eq.
- On push with `in_set_flags=1`, `status` <= incoming flags.
- On push with `in_set_flags=0`, `status` holds.
- Pushes with `in_valid=0` or while not ready have no effect on any state.
- Results are delivered in push order with no reordering or dropping.

## Timing
- Reset values: count 0, pointers 0, `out_valid` 0, `in_ready` 1, `out_data` 0, `out_rd` 0, `out_br_taken` 0, `status` 0, `trap` 0.
- `in_ready` = (count != 2). It is derived from registered count only, with no combinational path from `out_ready`.
- `out_valid` = (count != 0). `out_*` always show the head entry.
- Latency: push at edge N gives `out_valid` high after edge N (visible in cycle N+1). `status` updates at the same edge.
- Sustained throughput is 1 per cycle when `out_ready` is held high.
- Count 1 with simultaneous push and pop: count stays 1, both pointers advance.
- Count 2: no push is possible. A pop gives count 1 and `in_ready` 1 in the next cycle.
- Count 0 with pop: impossible, since `out_valid` is 0.
- Pointers wrap modulo 2.
- Reset asserted mid-stream: all entries are discarded immediately (asynchronous) and outputs return to reset values. No pushes are accepted until the first rising edge after deassertion.

## Configuration
- `ALU_RESULT_STAGE_OVF_TRAP_EN` defined:
  - `trap` sets on a push where `in_ovf=1` and `in_alu_op` is 2 or 6.
  - `trap` stays set until `trap_clr` is sampled high.
  - If set and clear happen in the same cycle, set wins.
- Macro undefined: `trap` is tied 0, `trap_clr` is ignored, and no trap flop is synthesized.

## Structure
- Shared package `risc_pkg` holds:
  - ALU opcode constants (`ALU_AND`=0, `ALU_OR`=1, `ALU_ADD`=2, `ALU_SUB`=6).
  - Branch-condition encodings.
  - Status-bit index constants.
- One sub-module, `br_eval`: combinational mapping of (`br_cond`, lt, eq, gt) to taken.
- FIFO and flag register stay in the top module.

## Test plan
- Reset, then push {data=500, lt=1, cond=3 (lt), set_flags=1} with `out_ready`=1: next cycle `out_valid`=1, `out_data`=500, `out_br_taken`=1, `status`=5'b10000.
- Back-to-back pushes of 1000 (eq) and 1500 (gt) with cond=2 (ne) and `out_ready`=1: outputs 1000/taken=0, then 1500/taken=1 on consecutive cycles, with `in_ready` never dropping.
- `out_ready`=0 and three pushes offered: two are accepted, `in_ready`=0 after the second, the third is held. Raising `out_ready` drains in order and `in_ready` returns 1 one cycle after the first pop.
- Push with `set_flags=0` after a flagged push: `status` unchanged.
- Macro on, SUB (op 6) with `in_ovf`=1: `trap`=1 next cycle, persists across later pushes, clears after `trap_clr`. Macro off: `trap` stays 0.
- `rst_n` low while the FIFO holds two entries: `out_valid`=0 and `status`=0 immediately, before any clock edge.
